// File: rtl/regfile_wb_pkg.sv
// regfile_wb_pkg: shared MIPS register-file widths, special indices and types
package regfile_wb_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;
  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_RA = 5'd31;
endpackage

// File: rtl/regfile_read_port.sv
// regfile_read_port: one combinational read port with zero-register and pending-write bypass
module regfile_read_port #(
  parameter int DATA_W = regfile_wb_pkg::DATA_W,
  parameter int ADDR_W = regfile_wb_pkg::ADDR_W,
  parameter int DEPTH = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              pend_valid,
  input  logic [ADDR_W-1:0] pend_addr,
  input  logic [DATA_W-1:0] pend_data,
  input  logic [DATA_W-1:0] regs [DEPTH],
  output logic [DATA_W-1:0] data
);
  import regfile_wb_pkg::*;
  // r0 is hardwired; an uncommitted write shadows the array entry it targets
  always_comb data = (addr == ADDR_W'(REG_ZERO)) ? '0 :
                     (pend_valid && pend_addr == addr) ? pend_data : regs[addr];
endmodule

// File: rtl/regfile_wb.sv
// regfile_wb: 32x32 register file with a one-entry pending write-back stage and two bypassed read ports
module regfile_wb #(
  parameter int DATA_W = regfile_wb_pkg::DATA_W,
  parameter int ADDR_W = regfile_wb_pkg::ADDR_W,
  parameter int DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              pend_valid,
  output logic [15:0]       wr_count
);
  import regfile_wb_pkg::*;
  logic [DATA_W-1:0] regs [DEPTH];
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;
  // capture the presented write while committing the previous one; r0 writes never become pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
      wr_count <= '0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      pend_valid <= wr_en && (wr_addr != ADDR_W'(REG_ZERO));
      pend_addr <= wr_addr;
      pend_data <= wr_data;
      if (pend_valid) begin
        regs[pend_addr] <= pend_data;
        wr_count <= wr_count + 16'd1;
      end
    end
  end
  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_rd_a (
    .addr(rd_addr_a), .pend_valid(pend_valid), .pend_addr(pend_addr),
    .pend_data(pend_data), .regs(regs), .data(rd_data_a)
  );
  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_rd_b (
    .addr(rd_addr_b), .pend_valid(pend_valid), .pend_addr(pend_addr),
    .pend_data(pend_data), .regs(regs), .data(rd_data_b)
  );
endmodule

// File: tb/tb_regfile_wb.sv
// tb_regfile_wb: scoreboard bench for regfile_wb against a cycle-level reference model
module tb_regfile_wb;
  logic clk = 1'b0;
  logic rst;
  logic wr_en;
  logic [4:0] wr_addr, rd_addr_a, rd_addr_b;
  logic [31:0] wr_data, rd_data_a, rd_data_b;
  logic pend_valid;
  logic [15:0] wr_count;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic pv;
    logic [15:0] cnt;
  } exp_t;
  exp_t exp_q[$];
  logic [31:0] m_arr [32];
  logic m_pv;
  logic [4:0] m_pa;
  logic [31:0] m_pd;
  logic [15:0] m_cnt;
  int n_tests = 0;
  int n_fail = 0;
  regfile_wb dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a),
    .rd_data_b(rd_data_b), .pend_valid(pend_valid), .wr_count(wr_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] m_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : (m_pv && m_pa == a) ? m_pd : m_arr[a];
  endfunction
  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_arr[i] = '0;
    m_pv = 1'b0;
    m_pa = '0;
    m_pd = '0;
    m_cnt = '0;
  endtask
  task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] ra, input logic [4:0] rb);
    exp_t e;
    wr_en = we;
    wr_addr = wa;
    wr_data = wd;
    rd_addr_a = ra;
    rd_addr_b = rb;
    exp_q.push_back('{m_rd(ra), m_rd(rb), m_pv, m_cnt});
    @(negedge clk);
    e = exp_q.pop_front();
    check("rd_a", rd_data_a, e.a);
    check("rd_b", rd_data_b, e.b);
    check("pend_valid", {31'd0, pend_valid}, {31'd0, e.pv});
    check("wr_count", {16'd0, wr_count}, {16'd0, e.cnt});
    @(posedge clk);
    if (m_pv) begin
      m_arr[m_pa] = m_pd;
      m_cnt = m_cnt + 16'd1;
    end
    m_pv = we && wa != 5'd0;
    m_pa = wa;
    m_pd = wd;
    #1;
  endtask
  initial begin
    rst = 1'b1;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr_a = 5'd8;
    rd_addr_b = 5'd31;
    m_reset();
    #7;
    check("reset_rd_a", rd_data_a, 32'd0);
    check("reset_rd_b", rd_data_b, 32'd0);
    check("reset_pv", {31'd0, pend_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b1, 5'd8, 32'hDEADBEEF, 5'd8, 5'd0);
    check("r8_bypass", rd_data_a, 32'hDEADBEEF);
    step(1'b0, 5'd0, 32'd0, 5'd8, 5'd8);
    check("r8_array", rd_data_a, 32'hDEADBEEF);
    check("r8_count", {16'd0, wr_count}, 32'd1);
    step(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    check("r0_pv", {31'd0, pend_valid}, 32'd0);
    check("r0_rd", rd_data_a, 32'd0);
    step(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    check("r0_count", {16'd0, wr_count}, 32'd1);
    step(1'b1, 5'd31, 32'h1, 5'd31, 5'd31);
    check("b2b_first", rd_data_a, 32'h1);
    step(1'b1, 5'd31, 32'h2, 5'd31, 5'd31);
    check("b2b_a", rd_data_a, 32'h2);
    check("b2b_b", rd_data_b, 32'h2);
    step(1'b0, 5'd0, 32'd0, 5'd31, 5'd31);
    check("b2b_a_arr", rd_data_a, 32'h2);
    check("b2b_b_arr", rd_data_b, 32'h2);
    check("b2b_count", {16'd0, wr_count}, 32'd3);
    step(1'b1, 5'd3, 32'hA, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
    wr_en = 1'b1;
    wr_addr = 5'd3;
    wr_data = 32'hB;
    #1;
    check("rdw_old", rd_data_a, 32'hA);
    step(1'b1, 5'd3, 32'hB, 5'd3, 5'd3);
    check("rdw_new", rd_data_a, 32'hB);
    for (int i = 0; i < 12; i++)
      step(1'($urandom_range(0, 1)), 5'($urandom), $urandom, 5'($urandom), 5'($urandom));
    step(1'b1, 5'd5, 32'h1234, 5'd5, 5'd5);
    check("rst_pre", rd_data_a, 32'h1234);
    wr_en = 1'b0;
    rd_addr_a = 5'd5;
    #2 rst = 1'b1;
    #1;
    check("rst_pv", {31'd0, pend_valid}, 32'd0);
    check("rst_r5", rd_data_a, 32'd0);
    check("rst_count", {16'd0, wr_count}, 32'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
    check("rst_r5_after", rd_data_a, 32'd0);
    for (int i = 0; i < 65536; i++) step(1'b1, 5'd1, 32'(i), 5'd1, 5'd2);
    step(1'b0, 5'd0, 32'd0, 5'd1, 5'd1);
    check("wrap_count", {16'd0, wr_count}, 32'd0);
    check("wrap_r1", rd_data_a, 32'd65535);
    check("wrap_r1_b", rd_data_b, 32'd65535);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
